mult_div_unit: RTL and testbench

- Iterative multiply/divide execution unit that consumes the 5-bit ALU control codes for the HI/LO operations: DIV=3, DIVU=4, MULT=11, MULTU=12.
- Owns the architectural HI/LO registers.
- Sits beside the single-cycle ALU in the execute stage. The controller stalls on busy before any MFHI/MFLO.
- Supports MTHI/MTLO writes.

---
 rtl/mips_alu_pkg.sv | 36 +++
 rtl/md_step.sv | 38 +++
 rtl/mult_div_unit.sv | 160 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mips_alu_pkg.sv
// Shared definitions for the MIPS execute stage: ALU control codes and the
// multiply/divide sequencer state encoding.
package mips_alu_pkg;

  localparam logic [4:0] ALU_AND     = 5'd0;
  localparam logic [4:0] ALU_OR      = 5'd1;
  localparam logic [4:0] ALU_ADD     = 5'd2;
  localparam logic [4:0] ALU_DIV     = 5'd3;
  localparam logic [4:0] ALU_DIVU    = 5'd4;
  localparam logic [4:0] ALU_XOR     = 5'd5;
  localparam logic [4:0] ALU_SUB     = 5'd6;
  localparam logic [4:0] ALU_SLT     = 5'd7;
  localparam logic [4:0] ALU_SLTU    = 5'd8;
  localparam logic [4:0] ALU_SLL     = 5'd9;
  localparam logic [4:0] ALU_SRL     = 5'd10;
  localparam logic [4:0] ALU_MULT    = 5'd11;
  localparam logic [4:0] ALU_MULTU   = 5'd12;
  localparam logic [4:0] ALU_SLLV    = 5'd13;
  localparam logic [4:0] ALU_SRLV    = 5'd14;
  localparam logic [4:0] ALU_SRA     = 5'd15;
  localparam logic [4:0] ALU_SRAV    = 5'd16;
  localparam logic [4:0] ALU_INVALID = 5'd31;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

  // True for the control codes that are executed by the HI/LO unit.
  function automatic logic is_md_op(input logic [4:0] ctl);
    return (ctl == ALU_DIV) || (ctl == ALU_DIVU) ||
           (ctl == ALU_MULT) || (ctl == ALU_MULTU);
  endfunction

endpackage

// File: rtl/md_step.sv
// One iteration of the multiply/divide datapath: a shift-add multiply step or
// a restoring divide step, chosen by mode_div.
module md_step #(
  parameter int WIDTH = 32
) (
  input  logic             mode_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    // Multiply: acc_lo holds the remaining multiplier bits, shifted out LSB first.
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    // Divide: acc_hi is the partial remainder, acc_lo the dividend/quotient.
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff    = shifted - {1'b0, operand};
    if (mode_div) begin
      if (!diff[WIDTH]) begin
        nxt_hi = diff[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = shifted[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers; one operand
// bit per cycle on magnitudes, with sign correction in a final FIX cycle.
module mult_div_unit
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       alu_ctl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Handshake: start is a request sampled only while busy is low; an accepted
  // request raises busy on the next cycle and completes with a one-cycle done
  // pulse coincident with the HI/LO update and busy falling.
  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             sign_a_q, sign_a_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0]   step_hi, step_lo;
  logic               accept, signed_op, div_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod, prod_fix;

  md_step #(.WIDTH(WIDTH)) u_step (
    .mode_div (is_div_q),
    .acc_hi   (acc_hi_q),
    .acc_lo   (acc_lo_q),
    .operand  (operand_q),
    .nxt_hi   (step_hi),
    .nxt_lo   (step_lo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    operand_d = operand_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    sign_a_d  = sign_a_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    accept    = (state_q == MD_IDLE) && start && is_md_op(alu_ctl);
    signed_op = (alu_ctl == ALU_DIV) || (alu_ctl == ALU_MULT);
    div_op    = (alu_ctl == ALU_DIV) || (alu_ctl == ALU_DIVU);
    a_neg     = signed_op && op_a[WIDTH-1];
    b_neg     = signed_op && op_b[WIDTH-1];
    a_mag     = a_neg ? -op_a : op_a;
    b_mag     = b_neg ? -op_b : op_b;
    prod      = {acc_hi_q, acc_lo_q};
    prod_fix  = neg_q ? -prod : prod;

    unique case (state_q)
      MD_IDLE: begin
        if (accept) begin
          state_d   = MD_RUN;
          cnt_d     = '0;
          is_div_d  = div_op;
          neg_d     = a_neg ^ b_neg;
          sign_a_d  = a_neg;
          dz_d      = (op_b == '0);
          acc_hi_d  = '0;
          acc_lo_d  = div_op ? a_mag : b_mag;
          operand_d = div_op ? b_mag : a_mag;
        end else begin
          if (hi_we) hi_d = wr_data;
          if (lo_we) lo_d = wr_data;
        end
      end
      MD_RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = MD_FIX;
      end
      MD_FIX: begin
        // A zero divisor leaves quotient all-ones and remainder |a|; restoring
        // a's sign on the remainder yields the raw dividend in HI.
        if (is_div_q) begin
          lo_d = (neg_q && !dz_q) ? -acc_lo_q : acc_lo_q;
          hi_d = sign_a_q ? -acc_hi_q : acc_hi_q;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase

    busy_d = (state_d != MD_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      operand_q <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      sign_a_q  <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      operand_q <= operand_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      sign_a_q  <= sign_a_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed HI/LO results, latency,
// ignore rules, MTHI/MTLO and mid-operation reset.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  alu_ctl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .alu_ctl (alu_ctl),
    .op_a    (op_a),
    .op_b    (op_b),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation and follow it to done; optionally disturb it at
  // cycle disturb_at with a competing start plus MTHI/MTLO writes.
  task automatic do_op(input string tag, input logic [4:0] ctl,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input int disturb_at);
    int n;
    int lapses;
    logic [31:0] held_hi;
    logic [31:0] held_lo;
    held_hi = hi;
    held_lo = lo;
    start = 1'b1; alu_ctl = ctl; op_a = a; op_b = b;
    tick();
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    n = 0;
    lapses = 0;
    while (!done && n < 40) begin
      if (!busy || hi !== held_hi || lo !== held_lo) lapses++;
      if (n == disturb_at) begin
        start = 1'b1; alu_ctl = 5'd12; op_a = 32'd9; op_b = 32'd9;
        hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h0000_1234;
      end
      tick();
      n++;
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    end
    check({tag, " latency"}, n, 33);
    check({tag, " busy_lapses"}, lapses, 0);
    check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
    tick();
    check({tag, " done_single"}, {31'd0, done}, 32'd0);
    check({tag, " hi_hold"}, hi, exp_hi);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; alu_ctl = 5'd0; op_a = '0; op_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
    tick();
    tick();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    rst_n = 1'b1;
    tick();

    do_op("multu_max", 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1);
    do_op("mult_m3x7", 5'd11, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, -1);
    do_op("div_m7d2", 5'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
    do_op("div_ovf", 5'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, -1);
    do_op("divu_5d0", 5'd4, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF, -1);
    do_op("div_m5d0", 5'd3, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, -1);
    do_op("divu_100d7", 5'd4, 32'd100, 32'd7, 32'd2, 32'd14, -1);
    do_op("multu_big", 5'd12, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 32'h242D_2080, -1);
    do_op("busy_ignore", 5'd4, 32'd100, 32'd7, 32'd2, 32'd14, 5);

    // MTHI alone, then MTHI and MTLO together, in IDLE.
    hi_we = 1'b1; wr_data = 32'h0000_1234;
    tick();
    hi_we = 1'b0;
    check("mthi hi", hi, 32'h0000_1234);
    check("mthi lo_keep", lo, 32'd14);
    hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h0000_ABCD;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    check("mt_both hi", hi, 32'h0000_ABCD);
    check("mt_both lo", lo, 32'h0000_ABCD);

    // Non-HI/LO control code is ignored.
    start = 1'b1; alu_ctl = 5'd2; op_a = 32'd1; op_b = 32'd2;
    tick();
    start = 1'b0;
    check("bad_ctl busy", {31'd0, busy}, 32'd0);
    tick();
    check("bad_ctl done", {31'd0, done}, 32'd0);
    check("bad_ctl hi", hi, 32'h0000_ABCD);
    check("bad_ctl lo", lo, 32'h0000_ABCD);

    // Reset in the middle of a MULT discards it.
    start = 1'b1; alu_ctl = 5'd11; op_a = 32'd5; op_b = 32'd9;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("mid_rst busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst busy", {31'd0, busy}, 32'd0);
    check("mid_rst done", {31'd0, done}, 32'd0);
    check("mid_rst hi", hi, 32'd0);
    check("mid_rst lo", lo, 32'd0);
    tick();
    check("post_rst idle_done", {31'd0, done}, 32'd0);
    do_op("multu_2x3", 5'd12, 32'd2, 32'd3, 32'd0, 32'd6, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
